// File: rtl/fb_pkg.sv
// Shared constants, state encoding and payload type for the framebuffer write path.
package fb_pkg;

    localparam int unsigned AW       = 15;
    localparam int unsigned DW       = 3;
    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned FB_SIZE  = SCREEN_W * SCREEN_H;
    localparam int unsigned CW       = $clog2(FB_SIZE);

    localparam logic [DW-1:0] COLOR_BLACK = 3'b000;
    localparam logic [DW-1:0] COLOR_WHITE = 3'b111;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } fb_state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } px_wr_t;

endpackage

// File: rtl/fb_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the last granted requester.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] last_q;
    logic [IW-1:0] last_d;
    logic [IW-1:0] idx;
    logic          found;

    // Rotating priority search; disabled search leaves the pointer frozen
    always_comb begin
        gnt    = '0;
        last_d = last_q;
        found  = 1'b0;
        idx    = '0;
        if (en) begin
            for (int unsigned k = 1; k <= NREQ; k++) begin
                idx = IW'((32'(last_q) + k) % NREQ);
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    last_d   = idx;
                    found    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= IW'(NREQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the framebuffer pixel-write port between NREQ drawing requesters and a full-screen clear engine.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               clr_start,
    input  logic [DW-1:0]      clr_color,
    output logic               clr_busy,
    output logic               clr_done,
    output logic               oob_drop,
    output logic [AW-1:0]      mem_px_addr,
    output logic [DW-1:0]      mem_px_data,
    output logic               px_wr
);

    fb_state_t     state_q;
    fb_state_t     state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [DW-1:0] color_q;
    logic [DW-1:0] color_d;

    logic            arb_en;
    logic [NREQ-1:0] gnt;
    px_wr_t          sel;
    logic            in_range;

    logic          px_wr_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] data_d;
    logic          clr_busy_d;
    logic          clr_done_d;
    logic          oob_drop_d;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .en  (arb_en),
        .gnt (gnt)
    );

    assign req_ready = gnt;

    // AND-OR mux of the granted requester's payload
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            sel.addr = sel.addr | ({AW{gnt[i]}} & req_addr[i*AW +: AW]);
            sel.data = sel.data | ({DW{gnt[i]}} & req_data[i*DW +: DW]);
        end
    end

    assign in_range = (32'(sel.addr) < FB_SIZE);

    // Next state and next values of the registered write port
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        color_d    = color_q;
        arb_en     = 1'b0;
        px_wr_d    = 1'b0;
        addr_d     = mem_px_addr;
        data_d     = mem_px_data;
        clr_busy_d = 1'b0;
        clr_done_d = 1'b0;
        oob_drop_d = 1'b0;

        unique case (state_q)
            ST_ARB: begin
                if (clr_start) begin
                    state_d    = ST_CLEAR;
                    cnt_d      = '0;
                    color_d    = clr_color;
                    clr_busy_d = 1'b1;
                end else begin
                    arb_en = 1'b1;
                    if (|gnt) begin
                        if (in_range) begin
                            px_wr_d = 1'b1;
                            addr_d  = sel.addr;
                            data_d  = sel.data;
                        end else begin
                            oob_drop_d = 1'b1;
                        end
                    end
                end
            end
            ST_CLEAR: begin
                px_wr_d = 1'b1;
                addr_d  = AW'(cnt_q);
                data_d  = color_q;
                // Port is handed back in the cycle the final clear write is presented
                if (cnt_q == CW'(FB_SIZE - 1)) begin
                    state_d    = ST_ARB;
                    clr_done_d = 1'b1;
                end else begin
                    cnt_d      = cnt_q + CW'(1);
                    clr_busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ARB;
            cnt_q       <= '0;
            color_q     <= COLOR_BLACK;
            px_wr       <= 1'b0;
            mem_px_addr <= '0;
            mem_px_data <= COLOR_BLACK;
            clr_busy    <= 1'b0;
            clr_done    <= 1'b0;
            oob_drop    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            color_q     <= color_d;
            px_wr       <= px_wr_d;
            mem_px_addr <= addr_d;
            mem_px_data <= data_d;
            clr_busy    <= clr_busy_d;
            clr_done    <= clr_done_d;
            oob_drop    <= oob_drop_d;
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: cycle-by-cycle model check plus hand-computed literal expectations.
module tb_fb_write_arbiter;
    import fb_pkg::*;

    localparam int unsigned NREQ = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]    req_ready;
    logic               clr_start = 1'b0;
    logic [DW-1:0]      clr_color = '0;
    logic               clr_busy;
    logic               clr_done;
    logic               oob_drop;
    logic [AW-1:0]      mem_px_addr;
    logic [DW-1:0]      mem_px_data;
    logic               px_wr;

    fb_write_arbiter #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .clr_start   (clr_start),
        .clr_color   (clr_color),
        .clr_busy    (clr_busy),
        .clr_done    (clr_done),
        .oob_drop    (oob_drop),
        .mem_px_addr (mem_px_addr),
        .mem_px_data (mem_px_data),
        .px_wr       (px_wr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Requester drivers: each sends total[i] pixels at base[i], base[i]+1, ...
    int base [NREQ];
    int dat  [NREQ];
    int total[NREQ];
    int sent [NREQ];

    // Behavioural model: rotating pointer, a pending-clear address count, expected port values
    int  m_last;
    bit  m_clr;
    int  m_idx;
    int  m_color;
    int  e_wr, e_addr, e_data, e_busy, e_done, e_oob;

    // Logs and counters for literal checks
    int gnt_log[$];
    int gnt_cyc[$];
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int oob_cyc[$];
    int done_cnt, clr_wr, clr_good, clr_next, clr_exp_color, rdy_busy;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic void drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]           = (sent[i] < total[i]);
            req_addr[i*AW +: AW]   = AW'(base[i] + sent[i]);
            req_data[i*DW +: DW]   = DW'(dat[i]);
        end
    endfunction

    function automatic void setup(input int i, input int b, input int d, input int n);
        base[i]  = b;
        dat[i]   = d;
        total[i] = n;
        sent[i]  = 0;
    endfunction

    function automatic void model_reset();
        m_last = NREQ - 1;
        m_clr  = 1'b0;
        m_idx  = 0;
        m_color = 0;
        e_wr = 0; e_addr = 0; e_data = 0; e_busy = 0; e_done = 0; e_oob = 0;
    endfunction

    function automatic void clear_logs();
        gnt_log.delete(); gnt_cyc.delete();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); oob_cyc.delete();
        done_cnt = 0; clr_wr = 0; clr_good = 0; clr_next = 0; rdy_busy = 0;
    endfunction

    // One clock: compare at the falling edge, advance model, then update drivers after the rising edge
    task automatic step();
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] ack;
        int g;
        int a;
        ack = '0;
        @(negedge clk);
        if (rst) begin
            model_reset();
        end else begin
            exp_rdy = '0;
            g = -1;
            if (!m_clr && !clr_start) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int j;
                    j = (m_last + k) % NREQ;
                    if (g < 0 && req_valid[j]) g = j;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;

            chk("req_ready",   int'(req_ready),   int'(exp_rdy));
            chk("px_wr",       int'(px_wr),       e_wr);
            chk("mem_px_addr", int'(mem_px_addr), e_addr);
            chk("mem_px_data", int'(mem_px_data), e_data);
            chk("clr_busy",    int'(clr_busy),    e_busy);
            chk("clr_done",    int'(clr_done),    e_done);
            chk("oob_drop",    int'(oob_drop),    e_oob);

            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    gnt_log.push_back(i);
                    gnt_cyc.push_back(cyc);
                end
            end
            if (px_wr) begin
                wr_addr.push_back(int'(mem_px_addr));
                wr_data.push_back(int'(mem_px_data));
                wr_cyc.push_back(cyc);
            end
            if (oob_drop) oob_cyc.push_back(cyc);
            if (clr_done) done_cnt++;
            if (clr_busy && req_ready != '0) rdy_busy++;
            if (px_wr && (clr_busy || clr_done)) begin
                clr_wr++;
                if (int'(mem_px_addr) == clr_next && int'(mem_px_data) == clr_exp_color) clr_good++;
                clr_next++;
            end

            e_wr = 0; e_done = 0; e_oob = 0;
            if (m_clr) begin
                e_wr   = 1;
                e_addr = m_idx;
                e_data = m_color;
                m_idx++;
                if (m_idx == FB_SIZE) begin
                    m_clr  = 1'b0;
                    e_done = 1;
                    e_busy = 0;
                end
            end else if (clr_start) begin
                m_clr   = 1'b1;
                m_idx   = 0;
                m_color = int'(clr_color);
                e_busy  = 1;
            end else if (g >= 0) begin
                m_last = g;
                a = int'(req_addr[g*AW +: AW]);
                if (a < FB_SIZE) begin
                    e_wr   = 1;
                    e_addr = a;
                    e_data = int'(req_data[g*DW +: DW]);
                end else begin
                    e_oob = 1;
                end
            end
            ack = req_valid & req_ready;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NREQ; i++) if (ack[i]) sent[i]++;
        drive();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_px_wr"},    int'(px_wr),       0);
        chk({tag, "_addr"},     int'(mem_px_addr), 0);
        chk({tag, "_data"},     int'(mem_px_data), 0);
        chk({tag, "_busy"},     int'(clr_busy),    0);
        chk({tag, "_done"},     int'(clr_done),    0);
        chk({tag, "_oob"},      int'(oob_drop),    0);
    endtask

    task automatic run_until_done();
        for (int t = 0; t < 20000 && done_cnt == 0; t++) step();
        for (int t = 0; t < 6; t++) step();
    endtask

    int exp_ord[8] = '{3, 0, 1, 2, 3, 0, 1, 2};

    initial begin
        for (int i = 0; i < NREQ; i++) setup(i, 0, 0, 0);
        drive();
        model_reset();
        clear_logs();
        #1;
        check_reset_outputs("rst0");
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();

        // Single requester 2 write
        clear_logs();
        setup(2, 100, 3'b111, 1);
        drive();
        repeat (4) step();
        chk("t1_ngnt",  gnt_log.size(), 1);
        chk("t1_gnt",   (gnt_log.size() > 0) ? gnt_log[0] : -1, 2);
        chk("t1_nwr",   wr_addr.size(), 1);
        chk("t1_addr",  (wr_addr.size() > 0) ? wr_addr[0] : -1, 100);
        chk("t1_data",  (wr_data.size() > 0) ? wr_data[0] : -1, 7);
        chk("t1_lat",   (wr_cyc.size() > 0 && gnt_cyc.size() > 0) ? wr_cyc[0] - gnt_cyc[0] : -1, 1);

        // All four continuously valid, two pixels each; pointer starts after requester 2
        clear_logs();
        for (int i = 0; i < NREQ; i++) setup(i, 1000 + 10 * i, i + 1, 2);
        drive();
        repeat (11) step();
        chk("t2_ngnt", gnt_log.size(), 8);
        for (int k = 0; k < 8; k++)
            chk("t2_order", (gnt_log.size() > k) ? gnt_log[k] : -1, exp_ord[k]);
        chk("t2_nwr",   wr_addr.size(), 8);
        chk("t2_span",  (wr_cyc.size() == 8) ? wr_cyc[7] - wr_cyc[0] : -1, 7);
        chk("t2_addr0", (wr_addr.size() > 0) ? wr_addr[0] : -1, 1030);
        chk("t2_data0", (wr_data.size() > 0) ? wr_data[0] : -1, 4);
        chk("t2_addr7", (wr_addr.size() > 7) ? wr_addr[7] : -1, 1021);
        chk("t2_data7", (wr_data.size() > 7) ? wr_data[7] : -1, 3);

        // Clear colour 001 started alongside pending requests 0 and 1
        clear_logs();
        clr_exp_color = 1;
        setup(0, 2000, 5, 1);
        setup(1, 2100, 6, 1);
        drive();
        clr_start = 1'b1;
        clr_color = 3'b001;
        step();
        clr_start = 1'b0;
        run_until_done();
        chk("t3_nclr",   clr_wr, 19200);
        chk("t3_good",   clr_good, 19200);
        chk("t3_done",   done_cnt, 1);
        chk("t3_rdy",    rdy_busy, 0);
        chk("t3_ngnt",   gnt_log.size(), 2);
        chk("t3_gnt0",   (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);
        chk("t3_gnt1",   (gnt_log.size() > 1) ? gnt_log[1] : -1, 1);
        chk("t3_wrlast", (wr_addr.size() > 0) ? wr_addr[wr_addr.size() - 1] : -1, 2100);

        // Second start pulse mid-clear is ignored
        clear_logs();
        clr_exp_color = 2;
        clr_start = 1'b1;
        clr_color = 3'b010;
        step();
        clr_start = 1'b0;
        repeat (5000) step();
        clr_start = 1'b1;
        clr_color = 3'b111;
        step();
        clr_start = 1'b0;
        run_until_done();
        chk("t4_nclr", clr_wr, 19200);
        chk("t4_good", clr_good, 19200);
        chk("t4_done", done_cnt, 1);

        // Out-of-range write from requester 1
        clear_logs();
        setup(1, 19200, 5, 1);
        drive();
        repeat (4) step();
        chk("t5_ngnt", gnt_log.size(), 1);
        chk("t5_gnt",  (gnt_log.size() > 0) ? gnt_log[0] : -1, 1);
        chk("t5_nwr",  wr_addr.size(), 0);
        chk("t5_noob", oob_cyc.size(), 1);
        chk("t5_lat",  (oob_cyc.size() > 0 && gnt_cyc.size() > 0) ? oob_cyc[0] - gnt_cyc[0] : -1, 1);
        chk("t5_hold_addr", int'(mem_px_addr), 19199);
        chk("t5_hold_data", int'(mem_px_data), 2);

        // Reset in the middle of a clear with requesters 0 and 2 pending
        clear_logs();
        clr_exp_color = 3;
        setup(0, 300, 1, 1);
        setup(2, 302, 2, 1);
        drive();
        clr_start = 1'b1;
        clr_color = 3'b011;
        step();
        clr_start = 1'b0;
        repeat (3000) step();
        chk("t6_busy_pre", int'(clr_busy), 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_rst");
        repeat (2) step();
        rst = 1'b0;
        clear_logs();
        repeat (10) step();
        chk("t6_done", done_cnt, 0);
        chk("t6_ngnt", gnt_log.size(), 2);
        chk("t6_gnt0", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);
        chk("t6_gnt1", (gnt_log.size() > 1) ? gnt_log[1] : -1, 2);
        chk("t6_addr", (wr_addr.size() > 0) ? wr_addr[0] : -1, 300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
